// File: rtl/nmos_bus_arbiter_pkg.sv
// Shared definitions for the NMOS pass-switch bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ON, DEAD)
//   rr_pick_w() : width of a requester index for n requesters
package nmos_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        DEAD = 2'd2
    } arb_state_t;

    function automatic int rr_pick_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nmos_bus_arbiter_if.sv
// Requester-side bundle between requester logic and the arbiter.
//   req      : per-requester bus request (level)
//   done     : per-requester release pulse
//   gate     : NMOS gate drives, one-hot or zero
//   grant_id : index of the current/last grant
//   busy     : arbiter not idle
//   timeout  : one-cycle pulse when a grant is revoked for holding too long
// modport master = requester side, modport slave = arbiter side.
interface nmos_bus_arbiter_if
    import nmos_ctrl_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int IW = rr_pick_w(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gate;
    logic [IW-1:0]    grant_id;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gate,
        input  grant_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gate,
        output grant_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/nmos_bus_arbiter_picker.sv
// Rotating-priority search: first set bit of req at or above ptr, wrapping.
//   req   : request vector
//   ptr   : search start index
//   valid : any request set
//   index : winning requester index
module nmos_rr_picker
    import nmos_ctrl_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [rr_pick_w(N_REQ)-1:0] ptr,
    output logic                        valid,
    output logic [rr_pick_w(N_REQ)-1:0] index
);
    localparam int IW = rr_pick_w(N_REQ);

    logic [N_REQ-1:0] rot;
    logic [IW:0]      sum;

    // Rotate so that bit 0 of rot is requester ptr, then take the lowest set bit
    // and map its offset back to an absolute index modulo N_REQ.
    always_comb begin
        rot   = N_REQ'({req, req} >> ptr);
        valid = 1'b0;
        sum   = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!valid && rot[j]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + (IW+1)'(j);
            end
        end
        if (sum >= (IW+1)'(N_REQ)) begin
            sum = sum - (IW+1)'(N_REQ);
        end
        index = sum[IW-1:0];
    end
endmodule

// File: rtl/nmos_bus_arbiter.sv
// Round-robin arbiter driving the gates of N_REQ NMOS pass switches that share
// one bus node. At most one gate is on; every handover passes through
// DEAD_CYCLES all-off cycles, and a grant is revoked after MAX_HOLD cycles.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of nmos_bus_arbiter_if (req/done in,
//                gate/grant_id/busy/timeout out, all outputs registered)
module nmos_bus_arbiter
    import nmos_ctrl_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DEAD_CYCLES = 1,
    parameter int MAX_HOLD    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    nmos_bus_arbiter_if.slave bus
);
    localparam int IW     = rr_pick_w(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

    localparam logic [IW-1:0]     LAST_IDX  = IW'(N_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES);

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("nmos_bus_arbiter: N_REQ must be 2..16");
    end
    if (DEAD_CYCLES < 1) begin : g_bad_dead
        $error("nmos_bus_arbiter: DEAD_CYCLES must be >= 1");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("nmos_bus_arbiter: MAX_HOLD must be >= 1");
    end

    arb_state_t        state_q, state_n;
    logic [N_REQ-1:0]  gate_q, gate_n;
    logic [IW-1:0]     gid_q, gid_n;
    logic [IW-1:0]     ptr_q, ptr_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic [DEAD_W-1:0] dead_q, dead_n;
    logic              busy_q, busy_n;
    logic              tmo_q, tmo_n;

    logic              pick_valid;
    logic [IW-1:0]     pick_idx;

    // A single picker serves both the IDLE and DEAD exits; both search from ptr_q.
    nmos_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_comb begin
        state_n = state_q;
        gate_n  = '0;
        gid_n   = gid_q;
        ptr_n   = ptr_q;
        hold_n  = hold_q;
        dead_n  = dead_q;
        tmo_n   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_n = ON;
                    gate_n  = N_REQ'(1) << pick_idx;
                    gid_n   = pick_idx;
                    ptr_n   = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
                    hold_n  = HOLD_W'(1);
                end
            end
            ON: begin
                // Release beats hold expiry, so a simultaneous done never flags timeout.
                if (bus.done[gid_q] || !bus.req[gid_q]) begin
                    state_n = DEAD;
                    dead_n  = DEAD_W'(1);
                end else if (hold_q == HOLD_MAX) begin
                    state_n = DEAD;
                    dead_n  = DEAD_W'(1);
                    tmo_n   = 1'b1;
                end else begin
                    gate_n  = gate_q;
                    hold_n  = hold_q + HOLD_W'(1);
                end
            end
            DEAD: begin
                if (dead_q == DEAD_LAST) begin
                    if (pick_valid) begin
                        state_n = ON;
                        gate_n  = N_REQ'(1) << pick_idx;
                        gid_n   = pick_idx;
                        ptr_n   = (pick_idx == LAST_IDX) ? '0 : pick_idx + IW'(1);
                        hold_n  = HOLD_W'(1);
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    dead_n = dead_q + DEAD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gate_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            dead_q  <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            gate_q  <= gate_n;
            gid_q   <= gid_n;
            ptr_q   <= ptr_n;
            hold_q  <= hold_n;
            dead_q  <= dead_n;
            busy_q  <= busy_n;
            tmo_q   <= tmo_n;
        end
    end

    assign bus.gate     = gate_q;
    assign bus.grant_id = gid_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = tmo_q;
endmodule

// File: doc/nmos_bus_arbiter.md
# nmos_bus_arbiter

Round-robin controller that shares one NMOS pass-transistor bus among N_REQ requesters by driving the gate inputs of N_REQ `mosfet_channel_n` switches, one per requester. At most one gate is high at any time. Every grant handover inserts a break-before-make dead time so two drains never connect to the shared source node together. The block sits between requester logic and the switch array, and is the only driver of the switch gates.

## Interface
- N_REQ, 4, number of requesters / pass switches (2..16)
- DEAD_CYCLES, 1, all-gates-off cycles between grants (>=1; 0 is illegal, elaboration error)
- MAX_HOLD, 8, maximum cycles one grant may stay on (>=1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester bus request, level
- done  in  N_REQ  per-requester release pulse; only the granted bit is honoured
- gate  out  N_REQ  NMOS gate drives, registered, one-hot or zero
- grant_id  out  $clog2(N_REQ)  index of the current/last grant
- busy  out  1  high whenever state is not IDLE
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD

## Operation
- Reset values: gate=0, grant_id=0, busy=0, timeout=0, pointer=0, hold count=0, dead count=0, state=IDLE.
- Assertion of rst_n low clears gate immediately, without waiting for clk, including mid-grant.
- **States:** IDLE, ON, DEAD.
- **IDLE:**
  - gate=0.
  - If any req is high at an edge: winner = first set req bit searching upward from pointer, wrapping modulo N_REQ.
  - On that edge: gate[winner]=1, grant_id=winner, pointer=winner+1 (mod N_REQ), hold=1, state goes to ON.
- **ON:** gate[grant_id]=1. At each edge, in priority order:
  1. done[grant_id]=1 or req[grant_id]=0: go to DEAD, gate=0.
  2. hold==MAX_HOLD: go to DEAD, gate=0, timeout=1 for one cycle.
  3. Otherwise: hold increments.
- **DEAD:**
  - gate=0 for exactly DEAD_CYCLES cycles, counted by the dead counter.
  - On the final dead cycle's edge, if any req is high: pick a winner as in IDLE (using the updated pointer), go to ON.
  - Otherwise go to IDLE.
- The previous owner may be granted again only if no other requester is pending. This falls out of the pointer advance.
- done bits not matching grant_id are ignored in every state. done in IDLE/DEAD is ignored.
- grant_id holds its last value in IDLE/DEAD.
- Counter widths: hold $clog2(MAX_HOLD+1), dead $clog2(DEAD_CYCLES+1). Neither counter wraps; each is reloaded on state entry.

## Timing
- Request to gate: req high before edge k in IDLE gives gate high after edge k (1-cycle latency).
- Release: done at edge k gives gate low after edge k. The next gate is high after edge k+DEAD_CYCLES at the earliest.
- Maximum on-time is MAX_HOLD cycles. timeout coincides with the first cycle of DEAD.
- Simultaneous done and hold expiry: done wins and timeout stays 0.
- Simultaneous req rising in IDLE for several bits: the lowest index at or above pointer wins, with wrap.
- busy rises with the first gate and falls on the cycle after DEAD exits to IDLE.
- All outputs are registered. There is no combinational path from req/done to gate.

## Structure
- Package `nmos_ctrl_pkg`: state enum (IDLE/ON/DEAD) and a `rr_pick` width helper constant for $clog2(N_REQ).
- Sub-module `nmos_rr_picker`: combinational rotate-priority search that takes (req, pointer) and returns (valid, index). It is reused by both the IDLE and DEAD exits.
- The top holds the FSM, hold/dead counters, pointer and gate register.
- The switch array (`mosfet_channel_n` ×N_REQ) is instantiated by the bench, not inside this block.

## Test plan
- **Reset mid-grant:** req=0001, wait 3 cycles, pulse rst_n low between edges. Required: gate=0000 immediately (before the next edge), busy=0, grant_id=0.
- **Single requester:** req=0100. Required: gate=0100 one cycle later. done[2] pulse gives gate=0000 for 1 cycle, then gate=0100 again if req stays high.
- **Round-robin fairness:** req=1111 held, each owner pulses done after 2 cycles. Required: grant order 0,1,2,3,0 with one all-zero cycle between each.
- **Timeout:** MAX_HOLD=8, req=0010 held, no done. Required: gate=0010 for exactly 8 cycles, then timeout=1 with gate=0000, then re-grant to 1.
- **Collision:** done[1] and hold expiry on the same edge. Required: timeout stays 0. A done pulse on a non-granted bit leaves gate unchanged.
- **Exclusivity:** random req/done for 10k cycles. Required: popcount(gate)<=1 every cycle, and no cycle switches gate directly from one set bit to a different one.
